// File: rtl/spc700_bcd_seq_pkg.sv
// spc700_bcd_seq_pkg -- shared definitions for the SPC700 multi-byte BCD
// add/subtract sequencer.
//   state_t / ST_*      : sequencer state encodings
//   CARRY_INIT_*        : carry value loaded at START (add = 0, sub = 1, i.e.
//                         "no borrow" for subtraction)
//   init_carry()        : selects the start carry for a given SUB flag
package spc700_bcd_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_BIN   = 3'd2;
    localparam state_t ST_ADJ   = 3'd3;
    localparam state_t ST_EMIT  = 3'd4;
    localparam state_t ST_FIN   = 3'd5;

    localparam logic CARRY_INIT_ADD = 1'b0;
    localparam logic CARRY_INIT_SUB = 1'b1;

    function automatic logic init_carry(input logic sub);
        return sub ? CARRY_INIT_SUB : CARRY_INIT_ADD;
    endfunction

endpackage

// File: rtl/spc700_bcd_seq_adj.sv
// SPC700_BCDAdj -- combinational decimal adjust of a binary add/sub result.
//   A   in  8 : binary result byte
//   ADD in  1 : direction select as wired by the sequencer (driven from SUB):
//               0 = adjust after add, 1 = adjust after subtract
//   CI  in  1 : binary carry (for subtract: 1 = no borrow)
//   HI  in  1 : half carry out of bit 3 (for subtract: 1 = no borrow)
//   R   out 8 : adjusted result, modulo 256
//   CO  out 1 : adjusted carry
module SPC700_BCDAdj (
    input  logic [7:0] A,
    input  logic       ADD,
    input  logic       CI,
    input  logic       HI,
    output logic [7:0] R,
    output logic       CO
);

    logic [7:0] step1;

    always_comb begin
        step1 = A;
        CO    = CI;
        // High digit: correct when the binary op produced the "wrong" carry
        // for its direction, or when the byte is out of BCD range.
        if ((CI == ~ADD) || (A > 8'h99)) begin
            step1 = ADD ? (A - 8'h60) : (A + 8'h60);
            CO    = ~ADD;
        end
        R = step1;
        if ((HI == ~ADD) || (step1[3:0] > 4'h9)) begin
            R = ADD ? (step1 - 8'h06) : (step1 + 8'h06);
        end
    end

endmodule

// File: rtl/spc700_bcd_seq.sv
// spc700_bcd_seq -- multi-byte BCD add/subtract sequencer, LSB byte first.
//   CLK, RST_N          : rising-edge clock, synchronous active-low reset
//   EN                  : clock enable, all state holds when low
//   START, SUB, LEN     : begin op (IDLE only), subtract select, bytes-1
//   ABORT               : cancel any in-progress operation
//   OP_VALID/OP_READY,
//   OPA, OPB            : operand byte handshake
//   RES_VALID/RES_READY,
//   RES                 : result byte handshake
//   BUSY, DONE          : not-idle flag, one-cycle completion pulse
//   CO, ZERO            : final carry (sub: 1 = no borrow), all-zero result
module spc700_bcd_seq
    import spc700_bcd_seq_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       START,
    input  logic       SUB,
    input  logic [1:0] LEN,
    input  logic       ABORT,
    input  logic       OP_VALID,
    input  logic [7:0] OPA,
    input  logic [7:0] OPB,
    output logic       OP_READY,
    output logic       RES_VALID,
    output logic [7:0] RES,
    input  logic       RES_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic       CO,
    output logic       ZERO
);

    state_t     state_q, state_d;
    logic       sub_q, sub_d;
    logic [1:0] len_q, len_d;
    logic [1:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] s_q, s_d;
    logic       c_q, c_d;
    logic       h_q, h_d;
    logic [7:0] res_q, res_d;

    logic [8:0] bin_raw;
    logic       bin_c;
    logic       bin_h;
    logic [7:0] adj_r;
    logic       adj_co;

    SPC700_BCDAdj u_adj (
        .A   (s_q),
        .ADD (sub_q),
        .CI  (c_q),
        .HI  (h_q),
        .R   (adj_r),
        .CO  (adj_co)
    );

    // Carry/borrow into bit 4 is recovered as a4 ^ b4 ^ s4 for both add and
    // subtract, so the full 9-bit result is the only adder needed.
    always_comb begin
        if (sub_q) begin
            bin_raw = {1'b0, a_q} - {1'b0, b_q} - {8'b0, ~carry_q};
            bin_c   = ~bin_raw[8];
            bin_h   = ~(a_q[4] ^ b_q[4] ^ bin_raw[4]);
        end else begin
            bin_raw = {1'b0, a_q} + {1'b0, b_q} + {8'b0, carry_q};
            bin_c   = bin_raw[8];
            bin_h   = a_q[4] ^ b_q[4] ^ bin_raw[4];
        end
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        h_d     = h_q;
        res_d   = res_q;
        if (EN) begin
            // ABORT outranks any handshake completing in the same cycle.
            if (ABORT && (state_q != ST_IDLE)) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (START && !ABORT) begin
                            sub_d   = SUB;
                            len_d   = LEN;
                            cnt_d   = '0;
                            carry_d = init_carry(SUB);
                            zero_d  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (OP_VALID) begin
                            a_d     = OPA;
                            b_d     = OPB;
                            state_d = ST_BIN;
                        end
                    end
                    ST_BIN: begin
                        s_d     = bin_raw[7:0];
                        c_d     = bin_c;
                        h_d     = bin_h;
                        state_d = ST_ADJ;
                    end
                    ST_ADJ: begin
                        res_d   = adj_r;
                        carry_d = adj_co;
                        if (adj_r != 8'h00) begin
                            zero_d = 1'b0;
                        end
                        state_d = ST_EMIT;
                    end
                    ST_EMIT: begin
                        if (RES_READY) begin
                            if (cnt_q == len_q) begin
                                state_d = ST_FIN;
                            end else begin
                                cnt_d   = cnt_q + 2'd1;
                                state_d = ST_FETCH;
                            end
                        end
                    end
                    ST_FIN: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sub_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            h_q     <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            h_q     <= h_d;
            res_q   <= res_d;
        end
    end

    assign OP_READY  = (state_q == ST_FETCH);
    assign RES_VALID = (state_q == ST_EMIT);
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_FIN);
    assign RES       = res_q;
    assign CO        = carry_q;
    assign ZERO      = zero_q;

endmodule
